// File: rtl/sme_pkg.sv
// Shared encodings and capacities for the string-match engine feeder.
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int STR_CAP = 32;
  localparam int PAT_CAP = 10;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/sme_feeder.sv
// Buffers a host-written string and pattern, streams them to a match engine
// and captures the engine result (or a timeout) for the host.
//
// state      | meaning
// S_IDLE     | host may write/clear buffers; waits for an accepted start
// S_SEND_STR | streams str[0..str_len-1] with isstring
// S_SEND_PAT | streams pat[0..pat_len-1] with ispattern
// S_WAIT     | waits for engine valid or the timeout
// S_DONE     | one-cycle done pulse, then back to idle
module sme_feeder
  import sme_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       clear,
  input  logic       start,
  input  logic       pat_only,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       ovf
);

  state_t     r_state, w_next;
  logic [7:0] r_str [STR_CAP];
  logic [7:0] r_pat [PAT_CAP];
  logic [5:0] r_str_len;
  logic [3:0] r_pat_len;
  logic [5:0] r_idx, w_idx_nxt;
  logic [7:0] r_cnt;
  logic [7:0] r_chardata, w_char_nxt;
  logic       r_isstring, r_ispattern, r_done;
  logic       r_res_match, r_res_timeout, r_ovf;
  logic [4:0] r_res_index;
  logic       w_idle, w_timeout, w_start_ok;
  logic       w_str_full, w_pat_full, w_str_wr, w_pat_wr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));
  assign w_str_full = (r_str_len == 6'(STR_CAP));
  assign w_pat_full = (r_pat_len == 4'(PAT_CAP));
  assign w_start_ok = w_idle && start && (r_pat_len != 4'd0) &&
                      (pat_only || (r_str_len != 6'd0));
  assign w_str_wr   = w_idle && !clear && wr_en && !wr_sel && !w_str_full;
  assign w_pat_wr   = w_idle && !clear && wr_en &&  wr_sel && !w_pat_full;

  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next    = pat_only ? S_SEND_PAT : S_SEND_STR;
          w_idx_nxt = '0;
        end
      end
      S_SEND_STR: begin
        if (r_idx == r_str_len - 6'd1) begin
          w_next    = S_SEND_PAT;
          w_idx_nxt = '0;
        end else begin
          w_idx_nxt = r_idx + 6'd1;
        end
      end
      S_SEND_PAT: begin
        if (r_idx[3:0] == r_pat_len - 4'd1) begin
          w_next    = S_WAIT;
          w_idx_nxt = '0;
        end else begin
          w_idx_nxt = r_idx + 6'd1;
        end
      end
      S_WAIT:  if (valid || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each character lines up
  // with its phase strobe in the same cycle the state is entered.
  always_comb begin
    w_char_nxt = 8'h00;
    if (w_next == S_SEND_STR)      w_char_nxt = r_str[w_idx_nxt[4:0]];
    else if (w_next == S_SEND_PAT) w_char_nxt = r_pat[w_idx_nxt[3:0]];
  end

  always_ff @(posedge clk) begin
    if (w_str_wr) r_str[r_str_len[4:0]] <= wr_data;
    if (w_pat_wr) r_pat[r_pat_len]      <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_chardata    <= '0;
      r_isstring    <= 1'b0;
      r_ispattern   <= 1'b0;
      r_done        <= 1'b0;
      r_res_match   <= 1'b0;
      r_res_index   <= '0;
      r_res_timeout <= 1'b0;
      r_ovf         <= 1'b0;
      r_str_len     <= '0;
      r_pat_len     <= '0;
    end else begin
      r_state     <= w_next;
      r_idx       <= w_idx_nxt;
      r_cnt       <= (r_state == S_WAIT) ? r_cnt + 8'd1 : 8'd0;
      r_chardata  <= w_char_nxt;
      r_isstring  <= (w_next == S_SEND_STR);
      r_ispattern <= (w_next == S_SEND_PAT);
      r_done      <= (w_next == S_DONE);
      if (r_state == S_WAIT) begin
        if (valid) begin
          r_res_match   <= match;
          r_res_index   <= match_index;
          r_res_timeout <= 1'b0;
        end else if (w_timeout) begin
          r_res_match   <= 1'b0;
          r_res_index   <= '0;
          r_res_timeout <= 1'b1;
        end
      end
      if (w_idle) begin
        if (clear) begin
          r_str_len <= '0;
          r_pat_len <= '0;
          r_ovf     <= 1'b0;
        end else if (wr_en) begin
          if (!wr_sel) begin
            if (w_str_full) r_ovf <= 1'b1;
            else            r_str_len <= r_str_len + 6'd1;
          end else begin
            if (w_pat_full) r_ovf <= 1'b1;
            else            r_pat_len <= r_pat_len + 4'd1;
          end
        end
      end
    end
  end

  assign busy        = !w_idle;
  assign chardata    = r_chardata;
  assign isstring    = r_isstring;
  assign ispattern   = r_ispattern;
  assign done        = r_done;
  assign res_match   = r_res_match;
  assign res_index   = r_res_index;
  assign res_timeout = r_res_timeout;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: a job table plus hand sequences for start
// filtering and reset during a job. The bench plays the match engine.
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0, wr_sel = 1'b0, clear = 1'b0;
  logic       start = 1'b0, pat_only = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       valid = 1'b0, match = 1'b0;
  logic [4:0] match_index = 5'd0;
  logic       busy, isstring, ispattern, done;
  logic       res_match, res_timeout, ovf;
  logic [7:0] chardata;
  logic [4:0] res_index;

  int total = 0;
  int bad = 0;
  int prev_rm = 0, prev_ri = 0, prev_rt = 0;

  sme_feeder #(.TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clear(clear), .start(start), .pat_only(pat_only),
    .busy(busy), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .done(done), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout), .ovf(ovf)
  );

  initial forever #5 clk = ~clk;

  // dly < 0: engine never answers
  typedef struct {
    bit         reload;
    string      s;
    string      p;
    bit         po;
    int         dly;
    bit         m;
    logic [4:0] idx;
    int         ns;
    int         np;
    bit         ovf;
    bit         rm;
    logic [4:0] ri;
    bit         rt;
    int         lat;
  } vec_t;

  vec_t vec [8];

  function automatic vec_t mk(bit reload, string s, string p, bit po, int dly,
                              bit m, logic [4:0] idx, int ns, int np, bit ov,
                              bit rm, logic [4:0] ri, bit rt, int lat);
    vec_t v;
    v.reload = reload; v.s = s; v.p = p; v.po = po; v.dly = dly;
    v.m = m; v.idx = idx; v.ns = ns; v.np = np; v.ovf = ov;
    v.rm = rm; v.ri = ri; v.rt = rt; v.lat = lat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input logic [7:0] ch);
    wr_en = 1'b1; wr_sel = sel; wr_data = ch;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input string s, input string p);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < s.len(); i++) wr(1'b0, s[i]);
    for (int i = 0; i < p.len(); i++) wr(1'b1, p[i]);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int ns, np, lat, w;
    bit ok, seen;
    bit exp_is, exp_ip;
    logic [7:0] exp_ch;
    v = vec[k];
    if (v.reload) load(v.s, v.p);
    chk($sformatf("v%0d ovf", k), int'(ovf), int'(v.ovf));
    ns = 0; np = 0; lat = -1; ok = 1'b1; seen = 1'b0;
    w = v.ns + v.np;
    start = 1'b1; pat_only = v.po;
    tick();
    start = 1'b0; pat_only = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      // stray valid during streaming, host writes/clear while busy
      valid       = (c == 0) || (v.dly >= 0 && c == w + v.dly);
      match       = (c == 0) ? 1'b1 : v.m;
      match_index = (c == 0) ? 5'd31 : v.idx;
      wr_en = (c == 1); wr_sel = 1'b0; wr_data = "Z";
      clear = (c == 2);
      exp_is = (c < v.ns);
      exp_ip = (c >= v.ns) && (c < w);
      exp_ch = exp_is ? v.s[c] : (exp_ip ? v.p[c - v.ns] : 8'h00);
      if (isstring) ns++;
      if (ispattern) np++;
      if (isstring !== exp_is || ispattern !== exp_ip ||
          chardata !== exp_ch || busy !== 1'b1) ok = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = c - w;
      end else if (res_match !== prev_rm[0] || res_index !== prev_ri[4:0] ||
                   res_timeout !== prev_rt[0]) begin
        ok = 1'b0;
      end
      tick();
    end
    valid = 1'b0; wr_en = 1'b0; clear = 1'b0;
    chk($sformatf("v%0d isstring cycles", k), ns, v.ns);
    chk($sformatf("v%0d ispattern cycles", k), np, v.np);
    chk($sformatf("v%0d stream", k), int'(ok), 1);
    chk($sformatf("v%0d done latency", k), lat, v.lat);
    chk($sformatf("v%0d done width/busy", k), int'({done, busy}), 0);
    chk($sformatf("v%0d res_match", k), int'(res_match), int'(v.rm));
    chk($sformatf("v%0d res_index", k), int'(res_index), int'(v.ri));
    chk($sformatf("v%0d res_timeout", k), int'(res_timeout), int'(v.rt));
    tick();
    chk($sformatf("v%0d res held", k),
        int'({res_match, res_index, res_timeout}), int'({v.rm, v.ri, v.rt}));
    prev_rm = v.rm; prev_ri = v.ri; prev_rt = v.rt;
  endtask

  initial begin
    int dcnt;
    vec[0] = mk(1, "hello world", "^wor", 0, 2,  1, 5'd6,  11, 4, 0, 1, 5'd6,  0, 3);
    vec[1] = mk(1, "hello world", "o$",   1, 0,  0, 5'd0,  0,  2, 0, 0, 5'd0,  0, 1);
    vec[2] = mk(0, "hello world", "o$",   1, 5,  1, 5'd31, 0,  2, 0, 1, 5'd31, 0, 6);
    vec[3] = mk(1, "hello world", "xyz",  0, 1,  0, 5'd0,  11, 3, 0, 0, 5'd0,  0, 2);
    vec[4] = mk(0, "hello world", "xyz",  0, 0,  1, 5'd17, 11, 3, 0, 1, 5'd17, 0, 1);
    vec[5] = mk(0, "hello world", "xyz",  0, -1, 1, 5'd9,  11, 3, 0, 0, 5'd0,  1, 255);
    vec[6] = mk(0, "hello world", "xyz",  0, 254, 1, 5'd3, 11, 3, 0, 1, 5'd3,  0, 255);
    vec[7] = mk(1, "abcdefghijklmnopqrstuvwxyz0123456", "abcdefghi^$",
                0, 0, 1, 5'd31, 32, 10, 1, 1, 5'd31, 0, 1);

    repeat (3) tick();
    chk("reset busy", int'(busy), 0);
    chk("reset chardata", int'(chardata), 0);
    chk("reset flags", int'({done, isstring, ispattern, res_match, res_index,
                             res_timeout, ovf}), 0);
    reset = 1'b1;
    tick();

    start = 1'b1; tick(); start = 1'b0;
    chk("start empty ignored", int'(busy), 0);
    wr(1'b0, "a"); wr(1'b0, "b");
    start = 1'b1; tick(); start = 1'b0;
    chk("start no pattern ignored", int'(busy), 0);
    load("", "a");
    start = 1'b1; tick(); start = 1'b0;
    chk("start no string ignored", int'(busy), 0);

    for (int k = 0; k < 8; k++) run_vec(k);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear ovf", int'(ovf), 0);

    load("hello world", "^wor");
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("midjob isstring", int'(isstring), 1);
    reset = 1'b0;
    #1;
    chk("abort isstring", int'(isstring), 0);
    chk("abort busy", int'(busy), 0);
    dcnt = 0;
    repeat (2) begin tick(); if (done) dcnt++; end
    reset = 1'b1;
    repeat (20) begin tick(); if (done || busy) dcnt++; end
    chk("abort no done", dcnt, 0);
    prev_rm = 0; prev_ri = 0; prev_rt = 0;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
